operand_fetch_stage: RTL and testbench

- Pipeline stage between instruction decode and execute. It is built around the 32x32 two-read/one-write register file (Clk, posedge write, combinational read).
- Drives the register file read addresses and captures both operands into an output register with a valid/ready handshake.
- Bypasses same-cycle write-back data, which the register file cannot yet return.
- Keeps a per-register busy scoreboard and stalls RAW and WAW hazards against in-flight producers.

---
 rtl/operand_fetch_stage.sv | 98 +++++++++
 tb/tb_operand_fetch_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: register file read, write-back bypass, busy scoreboard
// with RAW/WAW stalls, and a valid/ready output register toward execute.
module operand_fetch_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ADDR  = 5
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [ADDR-1:0]       InRs,
  input  logic [ADDR-1:0]       InRt,
  input  logic [ADDR-1:0]       InRd,
  input  logic                  InWritesRd,
  output logic [ADDR-1:0]       ReadRegister1,
  output logic [ADDR-1:0]       ReadRegister2,
  input  logic [WIDTH-1:0]      ReadData1,
  input  logic [WIDTH-1:0]      ReadData2,
  input  logic                  WbRegWrite,
  input  logic [ADDR-1:0]       WbRegister,
  input  logic [WIDTH-1:0]      WbData,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [WIDTH-1:0]      OutA,
  output logic [WIDTH-1:0]      OutB,
  output logic [ADDR-1:0]       OutRd,
  output logic                  OutWritesRd,
  output logic [(2**ADDR)-1:0]  Busy
);

  localparam int unsigned NREG = 2**ADDR;

  logic             wb_hit_a;
  logic             wb_hit_b;
  logic             wb_hit_d;
  logic             raw_a;
  logic             raw_b;
  logic             waw;
  logic             slot_free;
  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [NREG-1:0]  busy_d;

  assign ReadRegister1 = InRs;
  assign ReadRegister2 = InRt;

  // Operand select, hazard detection and next scoreboard state
  always_comb begin
    wb_hit_a  = WbRegWrite && (WbRegister == InRs);
    wb_hit_b  = WbRegWrite && (WbRegister == InRt);
    wb_hit_d  = WbRegWrite && (WbRegister == InRd);

    op_a = ReadData1;
    if (wb_hit_a)      op_a = WbData;
    if (InRs == '0)    op_a = '0;
    op_b = ReadData2;
    if (wb_hit_b)      op_b = WbData;
    if (InRt == '0)    op_b = '0;

    // A producer finishing this cycle resolves its hazard through the bypass
    raw_a     = (InRs != '0) && Busy[InRs] && !wb_hit_a;
    raw_b     = (InRt != '0) && Busy[InRt] && !wb_hit_b;
    waw       = InWritesRd && (InRd != '0) && Busy[InRd] && !wb_hit_d;
    slot_free = !OutValid || OutReady;
    InReady   = !raw_a && !raw_b && !waw && slot_free;
    accept    = InValid && InReady;

    // Clear first so a same-cycle set of the same bit wins
    busy_d = Busy;
    if (WbRegWrite)            busy_d[WbRegister] = 1'b0;
    if (accept && InWritesRd)  busy_d[InRd]       = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      OutValid    <= 1'b0;
      OutA        <= '0;
      OutB        <= '0;
      OutRd       <= '0;
      OutWritesRd <= 1'b0;
      Busy        <= '0;
    end else begin
      Busy <= busy_d;
      if (accept) begin
        OutValid    <= 1'b1;
        OutA        <= op_a;
        OutB        <= op_b;
        OutRd       <= InRd;
        OutWritesRd <= InWritesRd;
      end else if (OutReady) begin
        OutValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: directed scenarios plus random
// traffic against a register-level reference model.
module tb_operand_fetch_stage;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned ADDR  = 5;
  localparam int unsigned NREG  = 32;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             InValid;
  logic             InReady;
  logic [ADDR-1:0]  InRs, InRt, InRd;
  logic             InWritesRd;
  logic [ADDR-1:0]  ReadRegister1, ReadRegister2;
  logic [WIDTH-1:0] ReadData1, ReadData2;
  logic             WbRegWrite;
  logic [ADDR-1:0]  WbRegister;
  logic [WIDTH-1:0] WbData;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] OutA, OutB;
  logic [ADDR-1:0]  OutRd;
  logic             OutWritesRd;
  logic [NREG-1:0]  Busy;

  operand_fetch_stage #(.WIDTH(WIDTH), .ADDR(ADDR)) dut (
    .Clk(Clk), .Reset(Reset),
    .InValid(InValid), .InReady(InReady),
    .InRs(InRs), .InRt(InRt), .InRd(InRd), .InWritesRd(InWritesRd),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WbRegWrite(WbRegWrite), .WbRegister(WbRegister), .WbData(WbData),
    .OutValid(OutValid), .OutReady(OutReady),
    .OutA(OutA), .OutB(OutB), .OutRd(OutRd), .OutWritesRd(OutWritesRd),
    .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Environment register file: combinational read, written just after posedge
  logic [WIDTH-1:0] rf [NREG];
  assign ReadData1 = rf[ReadRegister1];
  assign ReadData2 = rf[ReadRegister2];

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [ADDR-1:0]  rd;
    logic             wr;
  } exp_t;

  exp_t q[$];
  bit   m_busy [NREG];   // registers with a pending producer
  bit   m_valid;         // an operand pair is waiting for execute
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_opnd(input logic [ADDR-1:0] src, input logic wbe,
                                                input logic [ADDR-1:0] wba, input logic [WIDTH-1:0] wbd);
    if (src == 0) return '0;
    if (wbe && wba == src) return wbd;
    return rf[src];
  endfunction

  // Register still waiting on a producer that is not finishing this cycle
  function automatic bit ref_pending(input logic [ADDR-1:0] r, input logic wbe, input logic [ADDR-1:0] wba);
    return (r != 0) && m_busy[r] && !(wbe && wba == r);
  endfunction

  function automatic logic [NREG-1:0] ref_busy_vec();
    logic [NREG-1:0] v = '0;
    for (int i = 0; i < int'(NREG); i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Monitor: every cycle the output register must match the oldest expectation
  initial begin
    forever begin
      @(negedge Clk);
      chk("out_valid", 32'(OutValid), 32'(m_valid));
      if (m_valid && q.size() > 0) begin
        chk("out_a",  OutA, q[0].a);
        chk("out_b",  OutB, q[0].b);
        chk("out_rd", 32'(OutRd), 32'(q[0].rd));
        chk("out_wr", 32'(OutWritesRd), 32'(q[0].wr));
        if (OutReady) void'(q.pop_front());
      end
    end
  end

  // One clock of stimulus; entered and left 1 time unit after a posedge
  task automatic step(input logic v, input logic [ADDR-1:0] rs, input logic [ADDR-1:0] rt,
                      input logic [ADDR-1:0] rd, input logic wr, input logic wbe,
                      input logic [ADDR-1:0] wba, input logic [WIDTH-1:0] wbd, input logic ordy);
    bit   exp_rdy;
    bit   acc;
    exp_t e;
    InValid = v; InRs = rs; InRt = rt; InRd = rd; InWritesRd = wr;
    WbRegWrite = wbe; WbRegister = wba; WbData = wbd; OutReady = ordy;
    @(negedge Clk);
    #1;
    exp_rdy = !ref_pending(rs, wbe, wba) && !ref_pending(rt, wbe, wba) &&
              !(wr && ref_pending(rd, wbe, wba)) && (!m_valid || ordy);
    chk("in_ready", 32'(InReady), 32'(exp_rdy));
    chk("busy", Busy, ref_busy_vec());
    chk("rd_addr1", 32'(ReadRegister1), 32'(rs));
    chk("rd_addr2", 32'(ReadRegister2), 32'(rt));
    acc = v && exp_rdy;
    if (acc) begin
      e.a = ref_opnd(rs, wbe, wba, wbd);
      e.b = ref_opnd(rt, wbe, wba, wbd);
      e.rd = rd;
      e.wr = wr;
      q.push_back(e);
    end
    @(posedge Clk);
    if (wbe) m_busy[wba] = 1'b0;
    if (acc && wr && rd != 0) m_busy[rd] = 1'b1;
    m_valid = acc ? 1'b1 : (ordy ? 1'b0 : m_valid);
    #1;
    if (wbe) rf[wba] = wbd;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, ordy);
  endtask

  task automatic wb(input logic [ADDR-1:0] r, input logic [WIDTH-1:0] d);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, r, d, 1'b1);
  endtask

  // Asynchronous reset pulse between clock edges; checked before any edge
  task automatic reset_pulse();
    InValid = 1'b0; WbRegWrite = 1'b0;
    #1 Reset = 1'b1;
    #1;
    chk("rst_out_valid", 32'(OutValid), 32'd0);
    chk("rst_out_a", OutA, 32'd0);
    chk("rst_out_b", OutB, 32'd0);
    chk("rst_out_rd", 32'(OutRd), 32'd0);
    chk("rst_out_wr", 32'(OutWritesRd), 32'd0);
    chk("rst_busy", Busy, 32'd0);
    Reset = 1'b0;
    m_valid = 1'b0;
    for (int i = 0; i < int'(NREG); i++) m_busy[i] = 1'b0;
    q.delete();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < int'(NREG); i++) begin
      rf[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_valid = 1'b0;
    Reset = 1'b1;
    InValid = 1'b0; InRs = '0; InRt = '0; InRd = '0; InWritesRd = 1'b0;
    WbRegWrite = 1'b0; WbRegister = '0; WbData = '0; OutReady = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    chk("init_out_valid", 32'(OutValid), 32'd0);
    chk("init_busy", Busy, 32'd0);

    // Reset during a stall: Busy[7] pending and output held by backpressure
    step(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    step(1'b1, 5'd7, 5'd0, 5'd1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("stall_busy", Busy, 32'h0000_0080);
    reset_pulse();

    // Plain read path
    wb(5'd2, 32'd42);
    wb(5'd3, 32'd15);
    step(1'b1, 5'd2, 5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    idle(1'b1);

    // Same-cycle write-back bypass on both sources
    step(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1);
    idle(1'b1);

    // RAW stall on r7 until its write-back arrives
    step(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
    repeat (3) step(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    step(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 32'd99, 1'b1);
    idle(1'b1);

    // Register zero reads as zero and is never marked busy
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 32'd42, 1'b1);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
    idle(1'b1);

    // WAW on r4 combined with output backpressure
    step(1'b1, 5'd1, 5'd0, 5'd4, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    step(1'b1, 5'd2, 5'd3, 5'd4, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    step(1'b1, 5'd2, 5'd3, 5'd4, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    step(1'b1, 5'd2, 5'd3, 5'd4, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
    step(1'b1, 5'd2, 5'd3, 5'd4, 1'b1, 1'b1, 5'd4, 32'h1234_5678, 1'b1);
    chk("waw_busy4", 32'(Busy[4]), 32'd1);
    idle(1'b1);

    // Random traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom(),
           1'($urandom_range(0, 3) != 0));
      if (n == 200) reset_pulse();
    end

    repeat (3) idle(1'b1);
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
